// File: rtl/polar_to_rect.sv
// polar_to_rect: fully pipelined rotation-mode CORDIC, (magnitude, phase) -> (x, y)
// scaled by the CORDIC gain K; latency NSTAGES+2 clock-enabled edges.
module polar_to_rect #(
    parameter int IW      = 12,
    parameter int PW      = 19,
    parameter int OW      = 14,
    parameter int WW      = 18,
    parameter int NSTAGES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic [IW-1:0]        i_mag,
    input  logic [PW-1:0]        i_phase,
    input  logic                 i_aux,
    output logic signed [OW-1:0] o_xval,
    output logic signed [OW-1:0] o_yval,
    output logic                 o_aux
);
    typedef logic signed [WW-1:0] xy_t;
    typedef logic signed [PW:0]   z_t;
    // round(atan(2^-i) * 2^PW / (2*pi)) for PW = 19
    localparam int ATAN [0:15] = '{65536, 38688, 20442, 10377, 5208, 2607, 1304, 652,
                                   326, 163, 81, 41, 20, 10, 5, 3};
    xy_t            r_x [0:NSTAGES];
    xy_t            r_y [0:NSTAGES];
    z_t             r_z [0:NSTAGES-1];
    logic [NSTAGES:0] r_aux;
    xy_t            w_m, w_x0, w_y0;
    z_t             w_z0;
    logic [1:0]     w_quad;
    // Quadrant pre-rotation leaves only the residual angle below 90 degrees.
    always_comb begin
        w_quad = i_phase[PW-1:PW-2];
        w_m    = xy_t'({i_mag, 4'b0000});
        w_x0   = (w_quad == 2'b00) ? w_m : (w_quad == 2'b10) ? -w_m : '0;
        w_y0   = (w_quad == 2'b01) ? w_m : (w_quad == 2'b11) ? -w_m : '0;
        w_z0   = z_t'({1'b0, i_phase[PW-3:0]});
    end
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i <= NSTAGES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            for (int i = 0; i < NSTAGES; i++) r_z[i] <= '0;
            r_aux  <= '0;
            o_xval <= '0;
            o_yval <= '0;
            o_aux  <= 1'b0;
        end else if (i_ce) begin
            r_x[0] <= w_x0;
            r_y[0] <= w_y0;
            r_z[0] <= w_z0;
            for (int i = 0; i < NSTAGES; i++) begin
                r_x[i+1] <= r_z[i][PW] ? r_x[i] + (r_y[i] >>> i) : r_x[i] - (r_y[i] >>> i);
                r_y[i+1] <= r_z[i][PW] ? r_y[i] - (r_x[i] >>> i) : r_y[i] + (r_x[i] >>> i);
            end
            for (int i = 0; i < NSTAGES-1; i++)
                r_z[i+1] <= r_z[i][PW] ? r_z[i] + z_t'(ATAN[i]) : r_z[i] - z_t'(ATAN[i]);
            r_aux  <= {r_aux[NSTAGES-1:0], i_aux};
            o_xval <= OW'((r_x[NSTAGES] + xy_t'(8)) >>> 4);
            o_yval <= OW'((r_y[NSTAGES] + xy_t'(8)) >>> 4);
            o_aux  <= r_aux[NSTAGES];
        end
    end
endmodule

// File: tb/tb_polar_to_rect.sv
// tb_polar_to_rect: directed checks of the CORDIC polar-to-rectangular pipeline.
module tb_polar_to_rect;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ce = 1'b0;
    logic [11:0]        mag = '0;
    logic [18:0]        phase = '0;
    logic               aux = 1'b0;
    logic signed [13:0] xval, yval;
    logic               oaux;
    int checks = 0;
    int errors = 0;

    polar_to_rect dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_mag(mag), .i_phase(phase),
        .i_aux(aux), .o_xval(xval), .o_yval(yval), .o_aux(oaux)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ce = 1'b1;
        tick;
        tick;
        checks++;
        if (xval !== 14'sd0 || yval !== 14'sd0 || oaux !== 1'b0) begin
            errors++;
            $display("FAIL reset_state x=%0d y=%0d aux=%0b required 0 0 0", xval, yval, oaux);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_quadrants;
        int vm [7] = '{1000, 1000, 4095, 2000, 2000, 1000, 1};
        int vp [7] = '{'h00000, 'h20000, 'h10000, 'h60000, 'h7FFFF, 'h40000, 'h00000};
        int ex [7] = '{1647, 0, 4768, 0, 3294, -1647, 2};
        int ey [7] = '{0, 1647, 4768, -3294, 0, 0, 0};
        int d;
        for (int k = 0; k < 7; k++) begin
            ce = 1'b1;
            mag = 12'(vm[k]);
            phase = 19'(vp[k]);
            aux = 1'b1;
            tick;
            mag = '0;
            phase = '0;
            aux = 1'b0;
            repeat (16) tick;
            checks++;
            if (oaux !== 1'b0) begin
                errors++;
                $display("FAIL aux_early vec%0d aux=%0b required 0 after 17 edges", k, oaux);
            end
            tick;
            checks++;
            d = int'(xval) - ex[k];
            if (d > 2 || d < -2) begin
                errors++;
                $display("FAIL xval vec%0d x=%0d required %0d+/-2", k, xval, ex[k]);
            end
            checks++;
            d = int'(yval) - ey[k];
            if (d > 2 || d < -2) begin
                errors++;
                $display("FAIL yval vec%0d y=%0d required %0d+/-2", k, yval, ey[k]);
            end
            checks++;
            if (oaux !== 1'b1) begin
                errors++;
                $display("FAIL aux_latency vec%0d aux=%0b required 1 after 18 edges", k, oaux);
            end
            tick;
            checks++;
            if (oaux !== 1'b0) begin
                errors++;
                $display("FAIL aux_late vec%0d aux=%0b required 0 after 19 edges", k, oaux);
            end
        end
    endtask

    task automatic test_zero_mag;
        int ph [5] = '{'h00000, 'h12345, 'h3FFFF, 'h5ABCD, 'h7FFFF};
        for (int k = 0; k < 5; k++) begin
            ce = 1'b1;
            mag = '0;
            phase = 19'(ph[k]);
            tick;
            phase = '0;
            repeat (17) tick;
            checks++;
            if (xval !== 14'sd0 || yval !== 14'sd0) begin
                errors++;
                $display("FAIL zero_mag ph=%0h x=%0d y=%0d required 0 0", ph[k], xval, yval);
            end
        end
    endtask

    task automatic test_ce_gating;
        int edges = 1;
        int d;
        logic signed [13:0] px, py;
        logic pa;
        ce = 1'b1;
        mag = 12'd1000;
        phase = 19'h20000;
        aux = 1'b1;
        tick;
        for (int cyc = 0; cyc < 200 && edges < 19; cyc++) begin
            px = xval;
            py = yval;
            pa = oaux;
            ce = cyc[0];
            mag = ce ? 12'd0 : 12'd4095;
            phase = ce ? 19'd0 : 19'h12345;
            aux = ~ce;
            tick;
            if (!ce) begin
                checks++;
                if (xval !== px || yval !== py || oaux !== pa) begin
                    errors++;
                    $display("FAIL ce_hold x=%0d y=%0d aux=%0b required %0d %0d %0b", xval, yval, oaux, px, py, pa);
                end
            end else begin
                edges++;
                if (edges == 17 || edges == 19) begin
                    checks++;
                    if (oaux !== 1'b0) begin
                        errors++;
                        $display("FAIL ce_aux edge%0d aux=%0b required 0", edges, oaux);
                    end
                end
                if (edges == 18) begin
                    checks++;
                    d = int'(yval) - 1647;
                    if (oaux !== 1'b1 || d > 2 || d < -2) begin
                        errors++;
                        $display("FAIL ce_data aux=%0b y=%0d required 1 1647+/-2", oaux, yval);
                    end
                end
            end
        end
        checks++;
        if (edges != 19) begin
            errors++;
            $display("FAIL ce_budget edges=%0d required 19", edges);
        end
        ce = 1'b1;
        mag = '0;
        phase = '0;
        aux = 1'b0;
    endtask

    task automatic test_back_to_back_reset;
        int sm [4] = '{500, 1000, 1500, 2000};
        logic sa [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int ex [4] = '{823, 1647, 2470, 3294};
        int d;
        ce = 1'b1;
        mag = 12'd1000;
        phase = '0;
        aux = 1'b1;
        repeat (20) tick;
        checks++;
        if (oaux !== 1'b1 || xval == 14'sd0) begin
            errors++;
            $display("FAIL stream_pre x=%0d aux=%0b required nonzero 1", xval, oaux);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (xval !== 14'sd0 || yval !== 14'sd0 || oaux !== 1'b0) begin
            errors++;
            $display("FAIL async_reset x=%0d y=%0d aux=%0b required 0 0 0", xval, yval, oaux);
        end
        mag = '0;
        aux = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            mag = (e <= 4) ? 12'(sm[e-1]) : 12'd0;
            aux = (e <= 4) ? sa[e-1] : 1'b0;
            tick;
            if (e <= 17) begin
                checks++;
                if (oaux !== 1'b0 || xval !== 14'sd0) begin
                    errors++;
                    $display("FAIL stale edge%0d x=%0d aux=%0b required 0 0", e, xval, oaux);
                end
            end else if (e <= 21) begin
                checks++;
                d = int'(xval) - ex[e-18];
                if (oaux !== sa[e-18] || d > 2 || d < -2) begin
                    errors++;
                    $display("FAIL b2b edge%0d x=%0d aux=%0b required %0d+/-2 %0b", e, xval, oaux, ex[e-18], sa[e-18]);
                end
            end else begin
                checks++;
                if (oaux !== 1'b0 || xval !== 14'sd0) begin
                    errors++;
                    $display("FAIL b2b_tail x=%0d aux=%0b required 0 0", xval, oaux);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_quadrants;
        test_zero_mag;
        test_ce_gating;
        test_back_to_back_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/polar_to_rect.md
POLAR_TO_RECT -- requirements
Module: polar_to_rect

Interface
REQ-001 Parameters SHALL be (name, default, meaning): IW, 12, magnitude input width; PW, 19, phase width; OW, 14, output width; WW, 18, internal x/y datapath width; NSTAGES, 16, CORDIC iteration stages.
REQ-002 Ports SHALL be (name direction width meaning):
- i_clk  input  1  sole clock, rising edge
- i_reset_n  input  1  asynchronous, active-low reset
- i_ce  input  1  clock enable; the pipeline advances only on edges where i_ce=1
- i_mag  input  IW  unsigned magnitude
- i_phase  input  PW  unsigned phase, full circle = 2^PW (0x20000 = 90 deg)
- i_aux  input  1  sideband flag, delayed alongside the data
- o_xval  output  OW  signed, K*mag*cos(phase)
- o_yval  output  OW  signed, K*mag*sin(phase)
- o_aux  output  1  i_aux delayed by the pipeline latency

Function
REQ-003 The block SHALL implement a fully pipelined rotation-mode CORDIC (polar to rectangular), accepting one sample on every i_ce=1 edge.
REQ-004 Stage P (pre-rotation) SHALL use i_phase[PW-1:PW-2] to select the quadrant. Magnitude is zero-extended and shifted left by 4 to form m.
- 00: x=m, y=0, z=phase
- 01: x=0, y=m, z=phase-2^17
- 10: x=-m, y=0, z=phase-2^18
- 11: x=0, y=-m, z=phase-3*2^17
REQ-005 z SHALL be held as signed PW+1 bits; after REQ-004 the residual z lies in [0, 2^17).
REQ-006 Stage i (i=0..NSTAGES-1) SHALL update x, y and z as follows:
- if z>=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-A[i]
- otherwise: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+A[i]
- >>> is an arithmetic shift.
REQ-007 A[i] SHALL equal round(atan(2^-i)*2^PW/(2*pi)); A[0]=65536 and A[1]=38688.
REQ-008 The output stage SHALL compute o_xval=(x+8)>>>4 and o_yval=(y+8)>>>4, i.e. round-half-up.
REQ-009 No gain compensation SHALL be applied. Outputs SHALL carry K~=1.64676 and match K*mag*cos/sin within +/-2 LSB over the whole input range.
REQ-010 WW=18 SHALL be sufficient without overflow: the worst case is 4095*16*K ~= 107,900 < 2^17.
REQ-011 Latency SHALL be exactly NSTAGES+2 = 18 i_ce=1 edges from input to output, for both the data and o_aux.
REQ-012 When i_ce=0, every pipeline register, including the aux chain, SHALL hold its value; outputs SHALL remain stable.
REQ-013 Phase SHALL wrap naturally: 2^PW-1 is treated as just below 360 deg, and there is no saturation or error path.
REQ-014 i_mag=0 SHALL give o_xval=o_yval=0 for every phase.
REQ-015 Outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-016 While i_reset_n=0, all x/y/z pipeline registers, o_xval, o_yval, o_aux and the aux chain SHALL clear to 0 immediately, independent of i_clk and i_ce.
REQ-017 A reset during operation SHALL discard all in-flight samples. After deassertion, o_aux SHALL stay 0 until 18 i_ce=1 edges carrying new input have elapsed.
REQ-018 Reset deassertion SHALL be taken synchronously to i_clk; the first capture occurs on the first i_ce=1 edge after release.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- i_mag=1000, i_phase=0, i_aux=1 -> after 18 ce-edges o_xval=1647+/-2, o_yval=0+/-2, o_aux=1.
- i_mag=1000, i_phase=0x20000 -> o_xval=0+/-2, o_yval=1647+/-2.
- i_mag=4095, i_phase=0x10000 (45 deg) -> o_xval=o_yval=4768+/-2.
- i_mag=2000, i_phase=0x60000 (270 deg) -> o_xval=0+/-2, o_yval=-3294+/-2; i_phase=0x7FFFF gives o_xval=3294+/-2, o_yval~=0.
- i_ce alternating 1/0 with a single-cycle i_aux pulse -> o_aux pulses after exactly 18 ce=1 edges; outputs unchanged on every ce=0 cycle.
- i_reset_n pulsed low while samples are streaming -> outputs and o_aux read 0 at once; after release, back-to-back samples emerge in order at 18-ce latency with no stale data.
